// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA raster counters, sync decode and registered pin stage
module vga_timing_gen #(
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int SYNC_ACTIVE = 0,
    parameter int EOF_LINE    = 481
) (
    input  logic       clk25M,
    input  logic       reset,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       vga_on,
    output logic       end_of_frame,
    output logic       line_start,
    input  logic [2:0] rgb_in,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_DISPLAY);
    localparam logic [9:0] V_ACT      = 10'(V_DISPLAY);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] EOF_Y      = 10'(EOF_LINE);
    localparam logic       SYNC_ON    = (SYNC_ACTIVE != 0);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       hsync_raw;
    logic       vsync_raw;

    // v_cnt only moves on the clock where h_cnt wraps, so both wrap together
    always_ff @(posedge clk25M or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign x            = h_cnt;
    assign y            = v_cnt;
    assign vga_on       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign line_start   = (h_cnt == 10'd0);
    assign end_of_frame = (h_cnt == 10'd0) && (v_cnt == EOF_Y);

    assign hsync_raw = ((h_cnt >= H_SYNC_BEG) && (h_cnt <= H_SYNC_END)) ? SYNC_ON : ~SYNC_ON;
    assign vsync_raw = ((v_cnt >= V_SYNC_BEG) && (v_cnt <= V_SYNC_END)) ? SYNC_ON : ~SYNC_ON;

    // Pin stage: rgb_in is derived from the same x/y, so syncs get the same one-clock delay
    always_ff @(posedge clk25M or posedge reset) begin
        if (reset) begin
            hsync <= ~SYNC_ON;
            vsync <= ~SYNC_ON;
            rgb   <= 3'b000;
        end else begin
            hsync <= hsync_raw;
            vsync <= vsync_raw;
            rgb   <= vga_on ? rgb_in : 3'b000;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed checks of full-size line timing and a scaled-down raster for frame behaviour
module tb_vga_timing_gen;

    localparam int BH   = 32;   // small raster: 16+4+6+6
    localparam int BV   = 21;   // small raster: 12+3+2+4
    localparam int BEOF = 13;

    logic       clk25M;
    logic       reset_a, reset_b;
    logic [2:0] rgb_in;

    logic [9:0] x_a, y_a, x_b, y_b;
    logic       vga_on_a, eof_a, ls_a, hsync_a, vsync_a;
    logic       vga_on_b, eof_b, ls_b, hsync_b, vsync_b;
    logic [2:0] rgb_a, rgb_b;

    int total = 0;
    int bad   = 0;

    vga_timing_gen dut_a (
        .clk25M(clk25M), .reset(reset_a), .x(x_a), .y(y_a), .vga_on(vga_on_a),
        .end_of_frame(eof_a), .line_start(ls_a), .rgb_in(rgb_in),
        .hsync(hsync_a), .vsync(vsync_a), .rgb(rgb_a)
    );

    vga_timing_gen #(
        .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
        .V_DISPLAY(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(4),
        .SYNC_ACTIVE(0), .EOF_LINE(BEOF)
    ) dut_b (
        .clk25M(clk25M), .reset(reset_b), .x(x_b), .y(y_b), .vga_on(vga_on_b),
        .end_of_frame(eof_b), .line_start(ls_b), .rgb_in(rgb_in),
        .hsync(hsync_b), .vsync(vsync_b), .rgb(rgb_b)
    );

    initial clk25M = 1'b0;
    always #20 clk25M = ~clk25M;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk25M);
        @(negedge clk25M);
    endtask

    initial begin
        int ex, ey, trk_err, hs_low, first_low_x, ls_cnt, green, vs_high_err;
        int k, eof_cnt, eof_pos_err, vs_low, eof_k[$];
        bit found;

        rgb_in  = 3'b010;
        reset_a = 1'b1;
        reset_b = 1'b1;

        // Full-size instance: reset state
        repeat (10) @(negedge clk25M);
        check("rst_x", x_a, 0);
        check("rst_y", y_a, 0);
        check("rst_vga_on", vga_on_a, 1);
        check("rst_line_start", ls_a, 1);
        check("rst_eof", eof_a, 0);
        check("rst_hsync", hsync_a, 1);
        check("rst_vsync", vsync_a, 1);
        check("rst_rgb", rgb_a, 0);

        reset_a = 1'b0;
        step();
        check("first_x", x_a, 1);

        // Two lines of the full-size raster
        ex = 1; ey = 0;
        trk_err = 0; hs_low = 0; first_low_x = -1; ls_cnt = 0; green = 0; vs_high_err = 0;
        for (int i = 0; i < 1600; i++) begin
            if (x_a != 10'(ex) || y_a != 10'(ey)) trk_err++;
            if (vga_on_a != ((ex < 640) && (ey < 480))) trk_err++;
            if (ey == 0 && !hsync_a) begin
                hs_low++;
                if (first_low_x < 0) first_low_x = ex;
            end
            if (ls_a) ls_cnt++;
            if (ey == 0 && rgb_a == 3'b010) green++;
            if (!vsync_a) vs_high_err++;
            step();
            if (ex == 799) begin ex = 0; ey = ey + 1; end
            else ex = ex + 1;
        end
        check("a_track", trk_err, 0);
        check("a_hsync_low_clks", hs_low, 96);
        check("a_hsync_first_x", first_low_x, 657);
        check("a_line_starts", ls_cnt, 2);
        check("a_green_line0", green, 640);
        check("a_vsync_idle", vs_high_err, 0);
        check("a_y_after_wrap", y_a, 2);

        // Small raster: three frames and a bit
        reset_b = 1'b0;
        ex = 0; ey = 0; k = 0;
        trk_err = 0; eof_cnt = 0; eof_pos_err = 0; vs_low = 0; green = 0;
        for (int i = 0; i < 2100; i++) begin
            step();
            k++;
            if (ex == BH - 1) begin ex = 0; ey = (ey == BV - 1) ? 0 : ey + 1; end
            else ex = ex + 1;
            if (x_b != 10'(ex) || y_b != 10'(ey)) trk_err++;
            if (eof_b) begin
                eof_cnt++;
                eof_k.push_back(k);
                if (x_b != 0 || y_b != BEOF || vga_on_b) eof_pos_err++;
            end
            if (k <= BH * BV) begin
                if (!vsync_b) vs_low++;
                if (rgb_b == 3'b010) green++;
            end
        end
        check("b_track", trk_err, 0);
        check("b_eof_count", eof_cnt, 3);
        check("b_eof_pos", eof_pos_err, 0);
        check("b_vsync_low_clks", vs_low, 2 * BH);
        check("b_green_per_frame", green, 16 * 12);
        if (eof_k.size() == 3) begin
            check("b_eof_first", eof_k[0], BH * BEOF);
            check("b_eof_period1", eof_k[1] - eof_k[0], BH * BV);
            check("b_eof_period2", eof_k[2] - eof_k[1], BH * BV);
        end

        // Mid-pulse reset on the small raster
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            if (x_b == 22 && y_b == 15) found = 1;
            else step();
        end
        check("b_reach_mid_sync", found, 1);
        check("b_pre_hsync", hsync_b, 0);
        check("b_pre_vsync", vsync_b, 0);
        #2 reset_b = 1'b1;
        #1;
        check("b_rst_hsync", hsync_b, 1);
        check("b_rst_vsync", vsync_b, 1);
        check("b_rst_rgb", rgb_b, 0);
        check("b_rst_x", x_b, 0);
        check("b_rst_y", y_b, 0);
        repeat (3) @(negedge clk25M);
        reset_b = 1'b0;
        k = 1;
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            step();
            k++;
            if (eof_b) found = 1;
        end
        check("b_eof_seen_after_rst", found, 1);
        check("b_eof_after_rst", k, BH * BEOF + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
